// File: rtl/if_pkg.sv
// ============================================================================
// Module      : if_pkg
// Description : Shared types and helpers for the instruction-fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// Module      : if_fetch_fifo
// Description : Registered DEPTH-entry FIFO with flush, occupancy and push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [XLEN-1:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  T                             push_data_i,
    input  logic                         pop_i,
    output T                             head_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           w_push;
    logic           w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : Fetch PC owner, in-order imem requester and decode skid buffer.
//               Optional IF_FETCH_PERF_CNT_EN adds stall/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [1:0]       settle_q;

    logic             w_req_fire;
    logic             w_rsp_live;
    logic             w_rsp_keep;
    logic             w_rsp_drop;
    logic             w_pop;
    logic [CW:0]      w_inflight;
    logic [WIDTH-1:0] w_pcq_head;
    logic             w_pcq_empty, w_pcq_full;
    logic [CW-1:0]    w_pcq_count;
    fetch_entry_t     w_push_entry, w_head;
    logic             w_fifo_empty, w_fifo_full;
    logic [CW-1:0]    w_fifo_count;

    // Responses with nothing outstanding (e.g. leftovers from before a reset) are ignored.
    assign w_rsp_live = imem_rsp_valid && (outstanding_q != '0);
    assign w_rsp_drop = w_rsp_live && ((drop_cnt_q != '0) || redirect_valid);
    assign w_rsp_keep = w_rsp_live && (drop_cnt_q == '0) && !redirect_valid;

    assign w_inflight     = {1'b0, outstanding_q} + {1'b0, w_fifo_count};
    assign imem_req_valid = rst && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc_d    = redirect_pc & ~WIDTH'(3);
            outstanding_d = outstanding_q - CW'(w_rsp_live);
            drop_cnt_d    = outstanding_q - CW'(w_rsp_live);
        end else begin
            if (w_req_fire) fetch_pc_d = next_pc(fetch_pc_q);
            outstanding_d = outstanding_q + CW'(w_req_fire) - CW'(w_rsp_live);
            if (w_rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            settle_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
        end
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [WIDTH-1:0])
    ) u_pc_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (w_req_fire),
        .push_data_i (imem_req_addr),
        .pop_i       (w_rsp_keep),
        .head_o      (w_pcq_head),
        .empty_o     (w_pcq_empty),
        .full_o      (w_pcq_full),
        .count_o     (w_pcq_count)
    );

    assign w_push_entry.pc    = w_pcq_head;
    assign w_push_entry.instr = imem_rsp_data;
    assign w_pop              = if_valid && if_ready;

    if_fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_instr_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (w_rsp_keep),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full),
        .count_o     (w_fifo_count)
    );

    assign if_valid = !w_fifo_empty;
    assign if_pc    = if_valid ? w_head.pc    : '0;
    assign if_instr = if_valid ? w_head.instr : '0;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (if_valid && !if_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if (w_rsp_drop && (perf_drop_q != '1))             perf_drop_q  <= perf_drop_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_dropped      = perf_drop_q;
`endif

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        (settle_q == 2'd2) && imem_rsp_valid |-> (outstanding_q != '0));
    a_bounds: assert property (@(posedge clk) disable iff (!rst)
        (outstanding_q <= CW'(DEPTH)) && (drop_cnt_q <= outstanding_q));
    a_pcq_tracks: assert property (@(posedge clk) disable iff (!rst)
        w_pcq_count == (outstanding_q - drop_cnt_q));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_fifo_full && w_rsp_keep && !w_pop) && !(w_pcq_full && w_req_fire)
        && !(w_rsp_keep && w_pcq_empty));

endmodule

`default_nettype wire
